// File: rtl/stride_prefetcher.sv
// Stride prefetcher: trains on demand line deltas and prefetches DEGREE lines into a small FIFO line buffer.
// Optional macro PREF_NEXTLINE_FALLBACK_EN: an unconfirmed demand in IDLE triggers a next-line (+1) prefetch.
module stride_prefetcher #(
  parameter int DEGREE     = 2,
  parameter int BUF_DEPTH  = 4,
  parameter int LINE_BYTES = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          lsq_pmem_read_cla,
  input  logic                          lsq_pmem_write_cla,
  input  logic [31:0]                   lsq_pmem_address_cla,
  input  logic                          arbiter_idle,
  input  logic                          pref_pmem_resp_cla,
  input  logic [255:0]                  pref_pmem_rdata_256_cla,
  output logic                          pref_pmem_read_cla,
  output logic [31:0]                   pref_pmem_address_cla,
  input  logic [31:0]                   buf_lookup_addr,
  output logic                          buf_hit,
  output logic [255:0]                  buf_hit_data,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(BUF_DEPTH)-1:0]  dbg_wr_ptr
);
  localparam int OFF = $clog2(LINE_BYTES);
  localparam int LW  = 32 - OFF;
  localparam int PW  = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_ARB, ISSUE, FILL} state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   last_line_q, stride_q, tgt_q, step_q;
  logic            confident_q;
  logic [2:0]      remaining_q;
  logic [31:0]     addr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [BUF_DEPTH-1:0] valid_q;
  logic [LW-1:0]   tag_q  [BUF_DEPTH];
  logic [255:0]    data_q [BUF_DEPTH];

  logic            demand, trig, conf_next, tgt_in_buf, last;
  logic            load, cancel, start_fill, advance, fill_done;
  logic [LW-1:0]   dline, delta, trig_step, fill_line, lk_line;
  logic            unused_bits;

  assign demand    = lsq_pmem_read_cla | lsq_pmem_write_cla;
  assign dline     = lsq_pmem_address_cla[31:OFF];
  assign delta     = dline - last_line_q;
  assign conf_next = (delta == stride_q) && (delta != '0);
  assign last      = (remaining_q == 3'd1);
  assign fill_line = addr_q[31:OFF];
  assign lk_line   = buf_lookup_addr[31:OFF];
  assign fill_done = (state_q == FILL) && pref_pmem_resp_cla;
  assign unused_bits = ^{lsq_pmem_address_cla[OFF-1:0], buf_lookup_addr[OFF-1:0]};

`ifdef PREF_NEXTLINE_FALLBACK_EN
  assign trig      = demand;
  assign trig_step = conf_next ? delta : LW'(1);
`else
  assign trig      = demand && conf_next;
  assign trig_step = delta;
`endif

  assign pref_pmem_read_cla    = (state_q == FILL);
  assign pref_pmem_address_cla = addr_q;
  assign dbg_state             = state_q;
  assign dbg_wr_ptr            = wr_ptr_q;

  always_comb begin
    tgt_in_buf   = 1'b0;
    buf_hit      = 1'b0;
    buf_hit_data = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == tgt_q) tgt_in_buf = 1'b1;
      if (valid_q[i] && tag_q[i] == lk_line) begin
        buf_hit      = 1'b1;
        buf_hit_data = data_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    cancel     = 1'b0;
    start_fill = 1'b0;
    advance    = 1'b0;
    case (state_q)
      IDLE: if (trig) begin
        load    = 1'b1;
        state_d = WAIT_ARB;
      end
      WAIT_ARB: begin
        if (demand) begin
          // any demand here abandons the current run; it may immediately start a new one
          if (trig) load = 1'b1;
          else begin
            cancel  = 1'b1;
            state_d = IDLE;
          end
        end else if (arbiter_idle) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (tgt_in_buf) begin
          advance = 1'b1;
          state_d = last ? IDLE : WAIT_ARB;
        end else begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: if (pref_pmem_resp_cla) begin
        advance = 1'b1;
        state_d = last ? IDLE : WAIT_ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_line_q <= '0;
      stride_q    <= '0;
      confident_q <= 1'b0;
      tgt_q       <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
    end else begin
      if (demand) begin
        last_line_q <= dline;
        stride_q    <= delta;
        confident_q <= conf_next;
      end
      // tgt_q always holds the next line to prefetch, so no multiplier is needed
      if (load) begin
        tgt_q       <= dline + trig_step;
        step_q      <= trig_step;
        remaining_q <= 3'(DEGREE);
      end else if (cancel) begin
        remaining_q <= '0;
      end else if (advance) begin
        remaining_q <= remaining_q - 3'd1;
        tgt_q       <= tgt_q + step_q;
      end
      if (start_fill) addr_q <= {tgt_q, {OFF{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (lsq_pmem_write_cla && valid_q[i] && tag_q[i] == dline) valid_q[i] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[wr_ptr_q] <= !(lsq_pmem_write_cla && dline == fill_line);
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[wr_ptr_q]  <= fill_line;
      data_q[wr_ptr_q] <= pref_pmem_rdata_256_cla;
    end
  end
endmodule

// File: tb/tb_stride_prefetcher.sv
// Bench for stride_prefetcher: directed demand streams, a memory responder, and a scoreboard of prefetch addresses.
module tb_stride_prefetcher;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         lsq_read = 1'b0, lsq_write = 1'b0;
  logic [31:0]  lsq_addr = '0;
  logic         arbiter_idle = 1'b0;
  logic         pref_resp;
  logic [255:0] pref_rdata;
  logic         pref_read;
  logic [31:0]  pref_addr;
  logic [31:0]  lookup_addr = '0;
  logic         buf_hit;
  logic [255:0] buf_hit_data;
  logic [1:0]   dbg_state;
  logic [1:0]   dbg_wr_ptr;

  int           checks = 0, errors = 0, read_cnt = 0, lat = 0;
  logic [31:0]  exp_q[$];
  bit           mem_en = 1'b1, prev_read = 1'b0;
  logic         mem_resp = 1'b0, man_resp = 1'b0;
  logic [255:0] mem_data = '0, man_data = '0;

  assign pref_resp  = mem_resp | man_resp;
  assign pref_rdata = man_resp ? man_data : mem_data;

  stride_prefetcher dut (
    .clk(clk), .rst(rst),
    .lsq_pmem_read_cla(lsq_read), .lsq_pmem_write_cla(lsq_write), .lsq_pmem_address_cla(lsq_addr),
    .arbiter_idle(arbiter_idle), .pref_pmem_resp_cla(pref_resp), .pref_pmem_rdata_256_cla(pref_rdata),
    .pref_pmem_read_cla(pref_read), .pref_pmem_address_cla(pref_addr),
    .buf_lookup_addr(lookup_addr), .buf_hit(buf_hit), .buf_hit_data(buf_hit_data),
    .dbg_state(dbg_state), .dbg_wr_ptr(dbg_wr_ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] line_data(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory model: answers each prefetch read after a short latency
  always @(posedge clk) begin
    mem_resp <= 1'b0;
    if (mem_en && pref_read && !mem_resp) begin
      if (lat == 2) begin
        mem_resp <= 1'b1;
        mem_data <= line_data(pref_addr);
        lat      <= 0;
      end else lat <= lat + 1;
    end else if (!pref_read) lat <= 0;
  end

  // scoreboard monitor: every accepted prefetch must match the next expected address
  always @(negedge clk) begin
    if (rst) begin
      if (pref_read && !prev_read) read_cnt++;
      prev_read = pref_read;
      if (pref_read && pref_resp) begin
        check("pref_align", {251'd0, pref_addr[4:0]}, 256'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got %0h expected none", pref_addr);
        end else begin
          check("pref_addr", {224'd0, pref_addr}, {224'd0, exp_q.pop_front()});
        end
      end
    end else prev_read = 1'b0;
  end

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic demand(input bit wr, input logic [31:0] a);
    lsq_read  = !wr;
    lsq_write = wr;
    lsq_addr  = a;
    @(posedge clk); #1;
    lsq_read  = 1'b0;
    lsq_write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (dbg_state == 2'd0 && exp_q.size() == 0) return;
      @(posedge clk); #1;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
    exp_q.delete();
  endtask

  task automatic probe(input string name, input logic [31:0] a, input bit hit, input logic [255:0] data);
    lookup_addr = a;
    #1;
    check({name, "_hit"}, {255'd0, buf_hit}, {255'd0, hit});
    if (hit) check({name, "_data"}, buf_hit_data, data);
  endtask

  initial begin
    int cnt0;
    repeat (2) @(posedge clk); #1;
    check("rst_read", {255'd0, pref_read}, 256'd0);
    check("rst_addr", {224'd0, pref_addr}, 256'd0);
    check("rst_state", {254'd0, dbg_state}, 256'd0);
    check("rst_wr_ptr", {254'd0, dbg_wr_ptr}, 256'd0);
    probe("rst_probe", 32'h0, 1'b0, '0);
    rst = 1'b1;
    @(posedge clk); #1;

    // stride of two lines
    arbiter_idle = 1'b1;
    exp_q.push_back(32'h10C0);
    exp_q.push_back(32'h1100);
    demand(0, 32'h1000);
    demand(0, 32'h1040);
    demand(0, 32'h1080);
    check("trig_state", {254'd0, dbg_state}, 256'd1);
    wait_idle("stride2");
    probe("lk_10c4", 32'h10C4, 1'b1, line_data(32'h10C0));
    probe("lk_1104", 32'h1104, 1'b1, line_data(32'h1100));
    // write to 0x10C0 invalidates it and retriggers: 0x1100 is skipped, 0x1140 fetched
    exp_q.push_back(32'h1140);
    demand(1, 32'h10C0);
    probe("lk_inval", 32'h10C0, 1'b0, '0);
    wait_idle("skip");
    probe("lk_1140", 32'h1140, 1'b1, line_data(32'h1140));
    probe("lk_1100b", 32'h1100, 1'b1, line_data(32'h1100));
    check("wr_ptr_3", {254'd0, dbg_wr_ptr}, 256'd3);

    // six distinct fills into a four-entry FIFO
    do_reset();
    foreach (exp_q[i]) exp_q.delete(i);
    for (int r = 0; r < 3; r++) begin
      logic [31:0] b;
      b = 32'h4000 + 32'(r) * 32'h2000;
      exp_q.push_back(b + 32'h60);
      exp_q.push_back(b + 32'h80);
      demand(0, b);
      demand(0, b + 32'h20);
      demand(0, b + 32'h40);
      wait_idle("fifo");
    end
    probe("fifo_4060", 32'h4060, 1'b0, '0);
    probe("fifo_4080", 32'h4080, 1'b0, '0);
    probe("fifo_6060", 32'h6060, 1'b1, line_data(32'h6060));
    probe("fifo_6080", 32'h6080, 1'b1, line_data(32'h6080));
    probe("fifo_8060", 32'h8060, 1'b1, line_data(32'h8060));
    probe("fifo_8080", 32'h8080, 1'b1, line_data(32'h8080));
    check("fifo_wr_ptr", {254'd0, dbg_wr_ptr}, 256'd2);

    // stride broken while waiting for the arbiter
    do_reset();
    arbiter_idle = 1'b0;
    demand(0, 32'h8000);
    demand(0, 32'h8040);
    demand(0, 32'h8080);
    check("cancel_wait", {254'd0, dbg_state}, 256'd1);
    cnt0 = read_cnt;
    demand(0, 32'h9000);
    check("cancel_idle", {254'd0, dbg_state}, 256'd0);
    arbiter_idle = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("cancel_noread", 256'(read_cnt - cnt0), 256'd0);

    // wrap at the top of the address space
    do_reset();
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0020);
    demand(0, 32'hFFFF_FFA0);
    demand(0, 32'hFFFF_FFC0);
    demand(0, 32'hFFFF_FFE0);
    wait_idle("wrap");
    probe("wrap_0", 32'h0, 1'b1, line_data(32'h0));
    probe("wrap_3c", 32'h3C, 1'b1, line_data(32'h20));
    do_reset();
    cnt0 = read_cnt;
    demand(0, 32'h2000);
    repeat (20) @(posedge clk); #1;
    check("single_noread", 256'(read_cnt - cnt0), 256'd0);
    check("single_idle", {254'd0, dbg_state}, 256'd0);

    // reset in the middle of a fill, then a stale response
    do_reset();
    mem_en = 1'b0;
    demand(0, 32'hA000);
    demand(0, 32'hA040);
    demand(0, 32'hA080);
    for (int i = 0; i < 50 && dbg_state != 2'd3; i++) begin
      @(posedge clk); #1;
    end
    check("mid_fill_state", {254'd0, dbg_state}, 256'd3);
    check("mid_fill_addr", {224'd0, pref_addr}, {224'd0, 32'hA0C0});
    rst = 1'b0;
    #1;
    check("rst_async_read", {255'd0, pref_read}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    man_data = line_data(32'hA0C0);
    man_resp = 1'b1;
    @(posedge clk); #1;
    man_resp = 1'b0;
    @(posedge clk); #1;
    check("post_read", {255'd0, pref_read}, 256'd0);
    check("post_addr", {224'd0, pref_addr}, 256'd0);
    check("post_state", {254'd0, dbg_state}, 256'd0);
    check("post_wr_ptr", {254'd0, dbg_wr_ptr}, 256'd0);
    probe("post_probe", 32'hA0C0, 1'b0, '0);
    mem_en = 1'b1;

    check("exp_q_empty", 256'(exp_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
